alu_result_fifo: RTL
====================

# alu_result_fifo

Buffers selected ALU results between the 8-to-1 result-select mux and the DMA controller. Each cycle the ALU asserts `wr_en`, the 32-bit mux output and its 3-bit select code are pushed as one entry. The DMAC pops entries at its own pace. Full and empty flags throttle both sides.

## Interface
Parameters:
- `DATA_WIDTH`, 32: result word width; matches mux output.
- `SEL_WIDTH`, 3: select-code tag width.
- `DEPTH`, 4: entry count; power of two, minimum 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: push request.
- `d_in` in DATA_WIDTH: result word from mux `d_out`.
- `sel_in` in SEL_WIDTH: select code that produced `d_in`.
- `rd_en` in 1: pop request from DMAC.
- `d_out` out DATA_WIDTH: head-entry data.
- `sel_out` out SEL_WIDTH: head-entry tag.
- `count` out $clog2(DEPTH)+1: occupied entries.
- `empty` out 1: high when count == 0.
- `full` out 1: high when count == DEPTH.
- `overflow` out 1: sticky dropped-push flag. Present only with `ALU_FIFO_OVERFLOW_EN`.

## Operation
- Show-ahead FIFO: `d_out`/`sel_out` present the head entry whenever `!empty`. Both are forced to 0 while empty.
- Storage: DEPTH entries of {sel, data}, with write and read pointers that wrap modulo DEPTH.
- FSM states are EMPTY, PARTIAL and FULL; all flags derive from the state and `count`.
  - EMPTY: push → PARTIAL (FULL if DEPTH==1, which is disallowed). Pop is ignored.
  - PARTIAL: push-only raises count by 1, and goes to FULL at DEPTH. Pop-only lowers count by 1, and goes to EMPTY at 0. Push+pop leaves count unchanged; data advances.
  - FULL: pop → PARTIAL. Push-only is dropped and no state changes. Push+pop is accepted: the head is popped, the new entry is written at the tail, and the state stays FULL.
- Push while EMPTY with `rd_en` high: the push is accepted and the pop is ignored, giving count 1.
- Pointer wrap: a pointer at DEPTH-1 moves to 0 and `count` is unaffected.
- Reset, asynchronous, including mid-transfer:
  - pointers, `count`, `full` and `overflow` → 0; `empty` → 1; `d_out` and `sel_out` → 0.
  - Stored contents are don't-care afterwards.

## Timing
- Push to visibility: an entry written at edge N appears on `d_out` and `empty` falls after edge N. One-cycle latency.
- Pop: when `rd_en` is sampled at edge N, the next entry, or 0 if now empty, appears after edge N.
- `count`, `full` and `empty` are registered. They update on the same edge as the push or pop.
- No combinational path exists from `wr_en`/`rd_en` to `d_out`.
- Throughput: one push and one pop per cycle.

## Configuration
- `ALU_FIFO_OVERFLOW_EN` defined:
  - `overflow` port exists.
  - Set on the edge where `wr_en` is high, `full` is high and `rd_en` is low.
  - Stays set until `reset_n` is asserted.
- Undefined: port and logic are absent. Dropped pushes are silent; all other behaviour is identical.

## Structure
- Shared package `alu_dmac_pkg`:
  - `DATA_WIDTH` and `SEL_WIDTH` constants.
  - FIFO state enum {EMPTY, PARTIAL, FULL}.
  - Entry struct {sel, data}.
- Sub-module `alu_fifo_mem`: DEPTH×(SEL_WIDTH+DATA_WIDTH) register array.
  - Synchronous write and combinational read.
  - Array has no reset.
- Top level holds the pointers, counter, FSM and the optional overflow flag.

## Test plan
- Reset then idle → `empty`=1, `full`=0, `count`=0, `d_out`=0, `sel_out`=0.
- Push 0x0000_00A1/sel 3'b001, then 0xDEAD_BEEF/sel 3'b111; pop twice → outputs appear in order (A1/001 then DEADBEEF/111), then `empty`=1 and `d_out`=0.
- Push 4 entries 0x10–0x13, then push 0x99 with no pop → `full`=1, `count`=4, 0x99 dropped. With the macro, `overflow`=1. Drain pops 0x10..0x13.
- FULL, push 0x55 with `rd_en` high → 0x10 popped, `count` stays 4, and 0x55 emerges after 0x13. Repeat across 8 cycles to exercise pointer wrap.
- EMPTY, push 0x77 and pop in the same cycle → `count`=1 and `d_out`=0x77 the next cycle.
- Assert `reset_n` low mid-stream with 3 entries held → `count`, `d_out` and `overflow` go to 0 immediately without a clock. After release, the first new push reads back correctly.

Source files
------------

// File: rtl/alu_dmac_pkg.sv
// Shared types and widths for the ALU result path into the DMA controller.
package alu_dmac_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned SEL_WIDTH  = 3;

  typedef enum logic [1:0] {
    StEmpty,
    StPartial,
    StFull
  } fifo_state_e;

  typedef struct packed {
    logic [SEL_WIDTH-1:0]  sel;
    logic [DATA_WIDTH-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/alu_fifo_mem.sv
// Unreset register array for the ALU result FIFO: synchronous write, combinational read.
module alu_fifo_mem #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 35
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_result_fifo.sv
// Show-ahead FIFO between the ALU result mux and the DMAC, tagging each word with its select code.
// Define ALU_FIFO_OVERFLOW_EN to add the sticky overflow output.
module alu_result_fifo #(
  parameter int unsigned DATA_WIDTH = alu_dmac_pkg::DATA_WIDTH,
  parameter int unsigned SEL_WIDTH  = alu_dmac_pkg::SEL_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    d_in,
  input  logic [SEL_WIDTH-1:0]     sel_in,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    d_out,
  output logic [SEL_WIDTH-1:0]     sel_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
`ifdef ALU_FIFO_OVERFLOW_EN
  ,
  output logic                     overflow
`endif
);

  import alu_dmac_pkg::*;

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned CntW   = AddrW + 1;
  localparam int unsigned EntryW = SEL_WIDTH + DATA_WIDTH;

  fifo_state_e      state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic             push_acc, pop_acc;
  logic [EntryW-1:0] rdata;

  // A push into a full FIFO only lands when a pop frees the head in the same cycle.
  assign push_acc = wr_en && ((state_q != StFull) || rd_en);
  assign pop_acc  = rd_en && (state_q != StEmpty);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + AddrW'(1);
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
    end

    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      StEmpty: begin
        if (push_acc) begin
          state_d = StPartial;
        end
      end
      StPartial: begin
        if (push_acc && !pop_acc && (count_q == CntW'(DEPTH - 1))) begin
          state_d = StFull;
        end else if (pop_acc && !push_acc && (count_q == CntW'(1))) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop_acc && !push_acc) begin
          state_d = StPartial;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StEmpty;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  alu_fifo_mem #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i ({sel_in, d_in}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign empty = (state_q == StEmpty);
  assign full  = (state_q == StFull);
  assign count = count_q;

  // Array contents are stale after reset, so the head is masked whenever empty.
  always_comb begin
    {sel_out, d_out} = '0;
    if (!empty) begin
      {sel_out, d_out} = rdata;
    end
  end

`ifdef ALU_FIFO_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (wr_en && full && !rd_en) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`else
  // Pushes into a full FIFO without a pop are dropped silently.
`endif

endmodule
